// File: rtl/timing_pkg.sv
// Shared timing types for the CPU control-path phase sequencer.
package timing_pkg;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_OP   = 2'd1,
        PH_INT  = 2'd2
    } phase_t;

    localparam int TW_DEFAULT = 3;

endpackage

// File: rtl/phase_sequencer_if.sv
// Handshake/status bundle between the control path and the phase sequencer.
// The master side drives stall, length and phase-termination requests;
// the slave side (the sequencer) returns cycle index, phase and strobes.
interface phase_sequencer_if #(parameter int TW = timing_pkg::TW_DEFAULT);
    import timing_pkg::*;

    logic          rdy;
    logic [TW-1:0] addr_len;
    logic [TW-1:0] op_len;
    logic          skip_addr;
    logic          early_end;
    logic          int_req;
    logic [TW-1:0] time_out;
    phase_t        phase;
    logic          last_cycle;
    logic          seq_start;
    logic          int_ack;

    modport master (
        output rdy, addr_len, op_len, skip_addr, early_end, int_req,
        input  time_out, phase, last_cycle, seq_start, int_ack
    );

    modport slave (
        input  rdy, addr_len, op_len, skip_addr, early_end, int_req,
        output time_out, phase, last_cycle, seq_start, int_ack
    );

endinterface

// File: rtl/phase_sequencer_counter.sv
// Per-phase cycle counter: restarts at 0 and latches the phase length on
// restart (or reset), otherwise counts up while advancing. Never wraps
// because the owner restarts it when the terminal count is reached.
module phase_counter #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          restart,
    input  logic [TW-1:0] len_d,
    output logic [TW-1:0] time_q,
    output logic          last
);

    logic [TW-1:0] len_q;

    // Cycle index and latched length; restart only takes effect when advancing.
    always_ff @(posedge clk) begin
        if (rst || (adv && restart)) begin
            time_q <= '0;
            len_q  <= len_d;
        end else if (adv) begin
            time_q <= time_q + TW'(1);
        end
    end

    // Terminal compare, independent of rdy.
    always_comb begin
        last = (time_q == len_q);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: steps instruction execution through ADDR, OP and
// (optionally) INT phases and exposes the per-phase cycle index.
// Optional feature macro: PHASE_SEQ_INT_PHASE_EN enables the INT phase.
module phase_sequencer
    import timing_pkg::*;
#(
    parameter int TW      = TW_DEFAULT,
    parameter int INT_LEN = 6
) (
    input logic                clk,
    input logic                rst,
    phase_sequencer_if.slave   bus
);

    phase_t        phase_q;
    phase_t        phase_d;
    logic          phase_end;
    logic [TW-1:0] len_d;
    logic [TW-1:0] time_q;
    logic          last;

    phase_counter #(.TW(TW)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .adv     (bus.rdy),
        .restart (phase_end),
        .len_d   (len_d),
        .time_q  (time_q),
        .last    (last)
    );

    // Phase-end detection, next phase and the length to latch on entry.
    always_comb begin
        phase_d   = phase_q;
        len_d     = bus.addr_len;
        phase_end = bus.rdy && (last ||
                                (phase_q == PH_ADDR && bus.skip_addr) ||
                                (phase_q == PH_OP   && bus.early_end));
        if (phase_end) begin
            case (phase_q)
                PH_ADDR: begin
                    phase_d = PH_OP;
                    len_d   = bus.op_len;
                end
                PH_OP: begin
`ifdef PHASE_SEQ_INT_PHASE_EN
                    if (bus.int_req) begin
                        phase_d = PH_INT;
                        len_d   = TW'(INT_LEN);
                    end else begin
                        phase_d = PH_ADDR;
                        len_d   = bus.addr_len;
                    end
`else
                    phase_d = PH_ADDR;
                    len_d   = bus.addr_len;
`endif
                end
                default: begin
                    phase_d = PH_ADDR;
                    len_d   = bus.addr_len;
                end
            endcase
        end
        if (rst) begin
            len_d = bus.addr_len;
        end
    end

    // Phase state register; reset always lands in ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifndef PHASE_SEQ_INT_PHASE_EN
    logic unused_int_req;
    assign unused_int_req = bus.int_req;
`endif

    // Outputs are registered state or decoded directly from it.
    always_comb begin
        bus.time_out   = time_q;
        bus.phase      = phase_q;
        bus.last_cycle = last;
        bus.seq_start  = (phase_q == PH_ADDR) && (time_q == '0);
`ifdef PHASE_SEQ_INT_PHASE_EN
        bus.int_ack    = (phase_q == PH_INT) && (time_q == '0);
`else
        bus.int_ack    = 1'b0;
`endif
    end

endmodule
